// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and register map for the UART channel
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [1:0] OFF_CTRL = 2'b00;
    localparam logic [1:0] OFF_TX   = 2'b10;
    localparam logic [1:0] OFF_RX   = 2'b11;

    localparam int CTRL_SEND   = 0;
    localparam int CTRL_NEW_RX = 1;

endpackage

// File: rtl/uart_nucleo.sv
// rtl/uart_nucleo.sv - 8N1 serial engine: baud counters, TX/RX FSMs, input synchronizer
module uart_nucleo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_done,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    input  logic       rx_i,
    output logic       tx_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    // Transmit path registers and next-state values
    uart_state_t   r_tx_state, w_tx_state_nx;
    logic [CW-1:0] r_tx_cnt,   w_tx_cnt_nx;
    logic [7:0]    r_tx_shift, w_tx_shift_nx;
    logic [2:0]    r_tx_bit,   w_tx_bit_nx;
    logic          r_tx_o,     w_tx_line_nx;
    logic          w_tx_done;

    // Receive path registers and next-state values
    logic          r_sync1, r_sync2;
    uart_state_t   r_rx_state, w_rx_state_nx;
    logic [CW-1:0] r_rx_cnt,   w_rx_cnt_nx;
    logic [7:0]    r_rx_shift, w_rx_shift_nx;
    logic [2:0]    r_rx_bit,   w_rx_bit_nx;
    logic          w_rx_valid;

    // TX state register; the line is registered so tx_o never glitches
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_tx_o     <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_tx_o     <= w_tx_line_nx;
        end
    end

    // TX next state: byte is captured on start so later register writes cannot disturb it
    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt;
        w_tx_shift_nx = r_tx_shift;
        w_tx_bit_nx   = r_tx_bit;
        w_tx_done     = 1'b0;
        case (r_tx_state)
            IDLE: begin
                if (i_tx_start) begin
                    w_tx_shift_nx = i_tx_byte;
                    w_tx_cnt_nx   = '0;
                    w_tx_state_nx = START;
                end
            end
            START: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_bit_nx   = '0;
                    w_tx_state_nx = DATA;
                end else begin
                    w_tx_cnt_nx = r_tx_cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nx = STOP;
                    end else begin
                        w_tx_bit_nx = r_tx_bit + 3'd1;
                    end
                end else begin
                    w_tx_cnt_nx = r_tx_cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_done     = 1'b1;
                    w_tx_state_nx = IDLE;
                end else begin
                    w_tx_cnt_nx = r_tx_cnt + CNT_ONE;
                end
            end
            default: w_tx_state_nx = IDLE;
        endcase
        case (w_tx_state_nx)
            START:   w_tx_line_nx = 1'b0;
            DATA:    w_tx_line_nx = w_tx_shift_nx[0];
            default: w_tx_line_nx = 1'b1;
        endcase
    end

    // RX synchronizer and state register; idle line level is 1
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rx_state <= IDLE;
            r_rx_cnt   <= '0;
            r_rx_shift <= '0;
            r_rx_bit   <= '0;
        end else begin
            r_sync1    <= rx_i;
            r_sync2    <= r_sync1;
            r_rx_state <= w_rx_state_nx;
            r_rx_cnt   <= w_rx_cnt_nx;
            r_rx_shift <= w_rx_shift_nx;
            r_rx_bit   <= w_rx_bit_nx;
        end
    end

    // RX next state: half-bit start check, then mid-bit sampling of data and stop
    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt;
        w_rx_shift_nx = r_rx_shift;
        w_rx_bit_nx   = r_rx_bit;
        w_rx_valid    = 1'b0;
        case (r_rx_state)
            IDLE: begin
                if (!r_sync2) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_state_nx = START;
                end
            end
            START: begin
                if (r_rx_cnt == HALF_LAST) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_bit_nx   = '0;
                    w_rx_state_nx = r_sync2 ? IDLE : DATA;
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + CNT_ONE;
                end
            end
            DATA: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_shift_nx = {r_sync2, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_nx = STOP;
                    end else begin
                        w_rx_bit_nx = r_rx_bit + 3'd1;
                    end
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + CNT_ONE;
                end
            end
            STOP: begin
                if (r_rx_cnt == BIT_LAST) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_valid    = r_sync2;
                    w_rx_state_nx = IDLE;
                end else begin
                    w_rx_cnt_nx = r_rx_cnt + CNT_ONE;
                end
            end
            default: w_rx_state_nx = IDLE;
        endcase
    end

    assign tx_o       = r_tx_o;
    assign o_tx_done  = w_tx_done;
    assign o_rx_valid = w_rx_valid;
    assign o_rx_byte  = r_rx_shift;

endmodule

// File: rtl/interfaz_uart.sv
// rtl/interfaz_uart.sv - memory-mapped UART channel: register bank, priority logic, read mux
module interfaz_uart
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [3:0]        addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    input  logic              rx_i,
    output logic              tx_o
);

    logic       r_send, r_new_rx;
    logic [7:0] r_tx_reg, r_rx_reg;

    logic [1:0] w_sel;
    logic       w_wr_ctrl, w_wr_tx;
    logic       w_tx_done, w_rx_valid;
    logic [7:0] w_rx_byte;
    logic       w_unused;

    assign w_sel     = addr_i[3:2];
    assign w_wr_ctrl = we_i && (w_sel == OFF_CTRL);
    assign w_wr_tx   = we_i && (w_sel == OFF_TX);
    assign w_unused  = ^{addr_i[1:0], data_i[DATA_W-1:8]};

    uart_nucleo #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_nucleo (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .i_tx_start (r_send),
        .i_tx_byte  (r_tx_reg),
        .o_tx_done  (w_tx_done),
        .o_rx_valid (w_rx_valid),
        .o_rx_byte  (w_rx_byte),
        .rx_i       (rx_i),
        .tx_o       (tx_o)
    );

    // Register bank; engine events take precedence over a same-cycle CPU write
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_send   <= 1'b0;
            r_new_rx <= 1'b0;
            r_tx_reg <= '0;
            r_rx_reg <= '0;
        end else begin
            if (w_tx_done) begin
                r_send <= 1'b0;
            end else if (w_wr_ctrl) begin
                r_send <= data_i[CTRL_SEND];
            end
            if (w_rx_valid) begin
                r_new_rx <= 1'b1;
            end else if (w_wr_ctrl) begin
                r_new_rx <= data_i[CTRL_NEW_RX];
            end
            if (w_wr_tx) begin
                r_tx_reg <= data_i[7:0];
            end
            if (w_rx_valid) begin
                r_rx_reg <= w_rx_byte;
            end
        end
    end

    // Read mux, purely combinational on the offset
    always_comb begin
        data_o = '0;
        case (w_sel)
            OFF_CTRL: begin
                data_o[CTRL_SEND]   = r_send;
                data_o[CTRL_NEW_RX] = r_new_rx;
            end
            OFF_TX:  data_o[7:0] = r_tx_reg;
            OFF_RX:  data_o[7:0] = r_rx_reg;
            default: data_o = '0;
        endcase
    end

endmodule
